// File: rtl/line_clear_if.sv
// Request/result bundle between move_piece and line_clear.
interface line_clear_if;
    logic        start;
    logic        touched;
    logic [31:0] board_in;
    logic [31:0] board_out;
    logic [3:0]  lines_cleared;
    logic [7:0]  score;
    logic [1:0]  spawn_type;
    logic [4:0]  spawn_location;
    logic [1:0]  spawn_rotation;
    logic        game_over;
    logic        busy;
    logic        done;

    modport master (
        output start, touched, board_in,
        input  board_out, lines_cleared, score, spawn_type, spawn_location,
               spawn_rotation, game_over, busy, done
    );

    modport slave (
        input  start, touched, board_in,
        output board_out, lines_cleared, score, spawn_type, spawn_location,
               spawn_rotation, game_over, busy, done
    );
endinterface

// File: rtl/line_clear.sv
// Locks a landed piece, compacts full rows one row per cycle, scores and spawns the next piece.
// Optional LINE_SCORE_EN builds the saturating score accumulator; otherwise score reads 0.
module line_clear (
    input  logic        clka,
    input  logic        reset,
    line_clear_if.slave bus
);
    localparam int unsigned BoardW = 32;
    localparam int unsigned RowW   = 4;
    localparam int unsigned RowIdW = 3;
    localparam int unsigned CntW   = 4;
    localparam int unsigned ScoreW = 8;
    localparam int unsigned LfsrW  = 8;
    localparam logic [LfsrW-1:0] LfsrSeed  = 8'hA5;
    localparam logic [4:0]       SpawnLoc  = 5'd29;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SPAWN, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [BoardW-1:0]  work_q, work_d, board_q, board_d;
    logic [RowIdW-1:0]  row_q, row_d;
    logic [CntW-1:0]    count_q, count_d, lines_q, lines_d;
    logic [LfsrW-1:0]   lfsr_q, lfsr_d;
    logic [1:0]         type_q, type_d, rot_q, rot_d;
    logic [4:0]         loc_q, loc_d;
    logic               over_q, over_d, busy_q, busy_d, done_q, done_d;

    logic [RowW-1:0]    cur_row_c;
    logic [BoardW-1:0]  keep_mask_c, shifted_c;

    // Rows below r stay put; rows above r drop by one and row 7 fills with zero.
    always_comb begin
        cur_row_c   = work_q[{row_q, 2'b00} +: RowW];
        keep_mask_c = (BoardW'(1) << {row_q, 2'b00}) - BoardW'(1);
        shifted_c   = (work_q & keep_mask_c) | ((work_q >> RowW) & ~keep_mask_c);
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        board_d = board_q;
        row_d   = row_q;
        count_d = count_q;
        lines_d = lines_q;
        lfsr_d  = lfsr_q;
        type_d  = type_q;
        rot_d   = rot_q;
        loc_d   = loc_q;
        over_d  = over_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !over_q) begin
                    if (bus.touched) begin
                        work_d  = bus.board_in;
                        row_d   = '0;
                        count_d = '0;
                        state_d = S_SCAN;
                    end else begin
                        board_d = bus.board_in;
                        lines_d = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_SCAN: begin
                if (cur_row_c == 4'hF) begin
                    work_d  = shifted_c;
                    count_d = count_q + CntW'(1);
                end else if (row_q == RowIdW'(7)) begin
                    state_d = S_SPAWN;
                end else begin
                    row_d = row_q + RowIdW'(1);
                end
            end
            S_SPAWN: begin
                board_d = work_q;
                lines_d = count_q;
                type_d  = lfsr_q[1:0];
                loc_d   = SpawnLoc;
                rot_d   = 2'b00;
                lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                if (work_q[31:28] != 4'h0) over_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            board_q <= '0;
            row_q   <= '0;
            count_q <= '0;
            lines_q <= '0;
            lfsr_q  <= LfsrSeed;
            type_q  <= '0;
            rot_q   <= '0;
            loc_q   <= '0;
            over_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            board_q <= board_d;
            row_q   <= row_d;
            count_q <= count_d;
            lines_q <= lines_d;
            lfsr_q  <= lfsr_d;
            type_q  <= type_d;
            rot_q   <= rot_d;
            loc_q   <= loc_d;
            over_q  <= over_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef LINE_SCORE_EN
    logic [ScoreW-1:0] score_q, score_d;
    logic [ScoreW:0]   sum_c;

    // Saturating accumulate of rows cleared.
    always_comb begin
        sum_c   = (ScoreW+1)'(score_q) + (ScoreW+1)'(count_q);
        score_d = score_q;
        if (state_q == S_SPAWN) score_d = sum_c[ScoreW] ? {ScoreW{1'b1}} : sum_c[ScoreW-1:0];
    end

    always_ff @(posedge clka) begin
        if (reset) score_q <= '0;
        else       score_q <= score_d;
    end

    assign bus.score = score_q;
`else
    assign bus.score = ScoreW'(0);
`endif

    assign bus.board_out      = board_q;
    assign bus.lines_cleared  = lines_q;
    assign bus.spawn_type     = type_q;
    assign bus.spawn_location = loc_q;
    assign bus.spawn_rotation = rot_q;
    assign bus.game_over      = over_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
endmodule

// File: tb/tb_line_clear.sv
// Randomized and directed bench for line_clear against a row-list reference model.
module tb_line_clear;
    logic clka = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;

    line_clear_if bus();
    line_clear dut (.clka(clka), .reset(reset), .bus(bus));

    always #5 clka = ~clka;

    // Reference model state
    logic [31:0] m_board;
    logic [3:0]  m_lines;
    int          m_score;
    logic [1:0]  m_type, m_rot;
    logic [4:0]  m_loc;
    logic        m_over;
    logic [7:0]  m_lfsr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] compact(input logic [31:0] b, output int k);
        logic [31:0] r;
        int n;
        r = '0; n = 0; k = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[4*i +: 4] == 4'hF) k++;
            else begin
                r[4*n +: 4] = b[4*i +: 4];
                n++;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_board = '0; m_lines = '0; m_score = 0; m_type = '0; m_rot = '0;
        m_loc = '0; m_over = 1'b0; m_lfsr = 8'hA5;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".board"}, bus.board_out, m_board);
        check_eq({tag, ".lines"}, 32'(bus.lines_cleared), 32'(m_lines));
`ifdef LINE_SCORE_EN
        check_eq({tag, ".score"}, 32'(bus.score), 32'(m_score));
`else
        check_eq({tag, ".score"}, 32'(bus.score), 32'd0);
`endif
        check_eq({tag, ".type"}, 32'(bus.spawn_type), 32'(m_type));
        check_eq({tag, ".loc"}, 32'(bus.spawn_location), 32'(m_loc));
        check_eq({tag, ".rot"}, 32'(bus.spawn_rotation), 32'(m_rot));
        check_eq({tag, ".over"}, 32'(bus.game_over), 32'(m_over));
    endtask

    task automatic do_reset();
        @(negedge clka);
        reset = 1'b1;
        bus.start = 1'b0;
        @(posedge clka); #1;
        model_reset();
        @(negedge clka);
        reset = 1'b0;
    endtask

    // One accepted operation; optional start noise while busy must have no effect.
    task automatic run_op(input string tag, input logic t, input logic [31:0] b, input bit noise);
        int k, lat, exp_lat;
        logic seen;
        logic [31:0] nb;
        @(negedge clka);
        bus.start = 1'b1; bus.touched = t; bus.board_in = b;
        @(posedge clka); #1;
        bus.start = 1'b0;
        if (t) begin
            nb = compact(b, k);
            exp_lat = 9 + k;
            check_eq({tag, ".busy"}, 32'(bus.busy), 32'd1);
            m_board = nb; m_lines = 4'(k);
            m_score = (m_score + k > 255) ? 255 : m_score + k;
            m_type = m_lfsr[1:0]; m_loc = 5'd29; m_rot = 2'b00;
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
            if (nb[31:28] != 4'h0) m_over = 1'b1;
        end else begin
            exp_lat = 0;
            m_board = b; m_lines = '0;
        end
        lat = 0;
        seen = bus.done;
        while (!seen && lat < 40) begin
            if (noise) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.touched = 1'($urandom_range(0, 1));
                bus.board_in = $urandom;
            end
            @(posedge clka); #1;
            lat++;
            seen = bus.done;
        end
        bus.start = 1'b0;
        check_eq({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check_all(tag);
        @(posedge clka); #1;
        check_eq({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        check_eq({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
        check_all({tag, ".stable"});
    endtask

    initial begin
        logic [31:0] rb;
        reset = 1'b0;
        bus.start = 1'b0; bus.touched = 1'b0; bus.board_in = '0;
        model_reset();
        do_reset();
        check_all("reset");
        check_eq("reset.busy", 32'(bus.busy), 32'd0);
        check_eq("reset.done", 32'(bus.done), 32'd0);

        run_op("single_clear", 1'b1, 32'h0000_00F1, 1'b0);
        check_eq("single_clear.type_const", 32'(bus.spawn_type), 32'd1);
        check_eq("single_clear.board_const", bus.board_out, 32'h0000_0001);
        run_op("no_clear", 1'b1, 32'h0000_0421, 1'b0);
        check_eq("no_clear.type_const", 32'(bus.spawn_type), 32'd2);
        run_op("pass_through", 1'b0, 32'h0000_00FF, 1'b0);
        run_op("non_adjacent", 1'b1, 32'h000F_3FFF, 1'b1);
        check_eq("non_adjacent.board_const", bus.board_out, 32'h0000_0003);

        // Random boards: each row full with probability ~1/3, restart after game over
        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < 8; r++) begin
                logic [3:0] row;
                row = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
                if (r == 7 && $urandom_range(0, 3) != 0) row = 4'hF;
                rb[4*r +: 4] = row;
            end
            run_op("random", 1'($urandom_range(0, 4) != 0), rb, 1'($urandom_range(0, 1)));
            if (m_over) do_reset();
        end

        // Saturation: all-full boards
        for (int i = 0; i < 33; i++) run_op("saturate", 1'b1, 32'hFFFF_FFFF, 1'b0);

        // Game over and ignored requests afterwards
        run_op("game_over", 1'b1, 32'h1000_0000, 1'b0);
        check_eq("game_over.flag", 32'(bus.game_over), 32'd1);
        @(negedge clka);
        bus.start = 1'b1; bus.touched = 1'b1; bus.board_in = 32'h0000_00F1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clka); #1;
            check_eq("over_ignore.busy", 32'(bus.busy), 32'd0);
            check_eq("over_ignore.done", 32'(bus.done), 32'd0);
        end
        bus.start = 1'b0;

        // Reset three edges into SCAN
        do_reset();
        run_op("pre_abort", 1'b1, 32'h0000_0F00, 1'b0);
        @(negedge clka);
        bus.start = 1'b1; bus.touched = 1'b1; bus.board_in = 32'h0000_FFFF;
        @(posedge clka); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clka);
        do_reset();
        check_all("abort");
        check_eq("abort.busy", 32'(bus.busy), 32'd0);
        run_op("after_abort", 1'b1, 32'h0000_00F1, 1'b0);
        check_eq("after_abort.type_const", 32'(bus.spawn_type), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/line_clear.md
# line_clear

Post-placement stage for the 4-column × 8-row Tetris board. It sits directly downstream of `move_piece` and is started when a move completes (`done`). When `touched` is also set, it takes `new_board_state` as its input and locks that board. The block then compacts full rows one row per cycle, updates the score, and issues the next piece (type, location, rotation) back to `move_piece`. It also flags game-over when the top row is occupied.

## Interface
- No parameters; board geometry fixed: row r occupies board bits [4r+3:4r], row 0 bottom, row 7 top.
- `clka` in 1: single system clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `touched` in 1: piece landed; sampled with `start`.
- `board_in` in 32: board with the active piece merged.
- `board_out` out 32: compacted board.
- `lines_cleared` out 4: rows cleared by the last operation, range 0–8.
- `score` out 8: total rows cleared, saturating at 255.
- `spawn_type` out 2: next piece type.
- `spawn_location` out 5: next piece cell index.
- `spawn_rotation` out 2: next piece rotation.
- `game_over` out 1: sticky until `reset`.
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle completion pulse.

## Operation
- **Reset values:** all outputs 0. `busy`=0, `done`=0, `game_over`=0. LFSR = 8'hA5. State = IDLE.
- **States:** IDLE, SCAN, SPAWN, DONE.
- **IDLE:**
  - Condition for acceptance: `start`=1 and `game_over`=0.
  - If `touched`=1: work ← `board_in`, r ← 0, count ← 0, go to SCAN.
  - If `touched`=0: `board_out` ← `board_in`, `lines_cleared` ← 0, go to DONE. Spawn outputs, score and LFSR are unchanged.
- **SCAN:** one row test per cycle.
  - If work row r = 4'hF: rows r..6 ← rows r+1..7, row 7 ← 0, count+1, r held.
  - Else: r+1.
  - When r would pass 7, go to SPAWN.
- **SPAWN:**
  - `board_out` ← work. `lines_cleared` ← count. `score` ← min(`score`+count, 255).
  - `spawn_type` ← LFSR[1:0]. `spawn_location` ← 5'd29 (row 7, column 1). `spawn_rotation` ← 2'b00.
  - LFSR advances once: shift left, new bit0 = b7^b5^b4^b3.
  - `game_over` ← 1 if work row 7 ≠ 0.
  - Go to DONE.
- **DONE:** `done`=1 for this cycle only, then return to IDLE.
- **LFSR:** advances only in SPAWN, never on a `touched`=0 operation.
  - First spawn after reset is type 2'b01.
  - Second spawn after reset is type 2'b10.

## Timing
- `start` is ignored while `busy`=1 or `game_over`=1; no `done` pulse follows an ignored request.
- SCAN takes exactly 8+k cycles, where k = rows cleared (k ≤ 8).
- **Latency, `touched`=1:** `done` high in the cycle after the (9+k)th rising edge following the accepting edge. Range: 9 edges (no clears) to 17 edges (all 8 rows full).
- **Latency, `touched`=0:** `done` high after 1 edge.
- **Output stability:** `board_out`, `lines_cleared`, `score` and the spawn outputs are written in SPAWN. They stay stable from the `done` cycle until the next accepted operation writes them.
- **Reset mid-operation:** reset takes priority on any edge. Abort to IDLE with all reset values, reseed the LFSR, clear `score` and `game_over`.
- **Score saturation:** `score`=250 with k=8 gives 255; it never wraps.
- **Game-over timing:** `game_over` rises in the same cycle that `done` is high.

## Configuration
- `LINE_SCORE_EN`:
  - Defined: `score` accumulates as described.
  - Undefined: no score register or adder is built and `score` is tied to 8'h00. All other behaviour is identical.

## Test plan
- **Single clear:** reset, then `start`=1 `touched`=1 with `board_in`=32'h0000_00F1 → after 10 edges `done`=1, `board_out`=32'h0000_0001, `lines_cleared`=1, `score`=1, `spawn_type`=01, `spawn_location`=29, `spawn_rotation`=0.
- **No clear:** next op `board_in`=32'h0000_0421, `touched`=1 → `done` after 9 edges, `board_out` unchanged, `lines_cleared`=0, `score`=1, `spawn_type`=10.
- **Pass-through:** `touched`=0 with `board_in`=32'h0000_00FF → `done` after 1 edge, `board_out`=32'h0000_00FF, `lines_cleared`=0, score and spawn outputs unchanged. The next spawn still follows the LFSR sequence.
- **Non-adjacent clears:** `board_in`=32'h000F_3FFF (rows 0, 1, 2, 4 full) → `done` after 13 edges, `board_out`=32'h0000_0003, `lines_cleared`=4. Also: `start` pulses while `busy`=1 are ignored.
- **Game over:** `board_in`=32'h1000_0000, `touched`=1 → `game_over`=1 with `done`. A following `start` gives no `busy` and no `done`.
- **Reset mid-SCAN, and macro off:**
  - Assert `reset` 3 edges into SCAN → all outputs 0. The next single-clear op yields `spawn_type`=01 again.
  - Rerun the single-clear scenario with `LINE_SCORE_EN` undefined → `score` stays 0.
